// File: rtl/musa_chk_pkg.sv
// rtl/musa_chk_pkg.sv - shared rule type, control bit indices, opcodes and window clamp
package musa_chk_pkg;

    localparam int CTRL_W = 10;

    localparam int CTRL_REG_DST    = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_DATA_A_S   = 5;
    localparam int CTRL_DATA_B_S   = 6;
    localparam int CTRL_PC_SRC     = 7;
    localparam int CTRL_POP        = 8;
    localparam int CTRL_PUSH       = 9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;

    typedef struct packed {
        logic              en;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic              funct_care;
        logic [CTRL_W-1:0] mask;
        logic [2:0]        win_min;
        logic [2:0]        win_max;
    } rule_t;

    // A zero window start is promoted to 1; an inverted or oversized window
    // collapses to [min(min,max_lat), max_lat].
    function automatic rule_t clamp_window(input rule_t r, input int max_lat);
        rule_t      o;
        logic [2:0] lim;
        o   = r;
        lim = 3'(max_lat);
        if (o.win_min == 3'd0) o.win_min = 3'd1;
        if ((o.win_max < o.win_min) || (o.win_max > lim)) begin
            o.win_max = lim;
            if (o.win_min > lim) o.win_min = lim;
        end
        return o;
    endfunction

endpackage

// File: rtl/chk_rule_tracker.sv
// rtl/chk_rule_tracker.sv - one rule slot: rule register, trigger match, age vector, violation strobe
module chk_rule_tracker
    import musa_chk_pkg::*;
#(
    parameter int MAX_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              cfg_we,
    input  rule_t             cfg_rule,
    output logic              fire,
    output logic              sat,
    output logic              viol
);

    rule_t              rule_q;
    logic [MAX_LAT:1]   pend_q;
    logic [MAX_LAT:0]   age;
    logic [MAX_LAT:0]   hit;
    logic [MAX_LAT-1:0] keep;
    logic               sat_now;
    logic               viol_d;

    // Match, in-window satisfaction, expiry at age max and the surviving entries
    always_comb begin
        fire    = rule_q.en && inst_valid && (opcode == rule_q.opcode) &&
                  (!rule_q.funct_care || (funct == rule_q.funct));
        sat_now = ((ctrl & rule_q.mask) == rule_q.mask);
        age     = {pend_q, fire};
        hit     = '0;
        keep    = '0;
        viol_d  = 1'b0;
        for (int k = 0; k <= MAX_LAT; k++) begin
            if ((k >= int'(rule_q.win_min)) && (k <= int'(rule_q.win_max)))
                hit[k] = age[k] & sat_now;
            if (k == int'(rule_q.win_max))
                viol_d = age[k] & ~hit[k];
        end
        for (int k = 0; k < MAX_LAT; k++) begin
            if (k < int'(rule_q.win_max))
                keep[k] = age[k] & ~hit[k];
        end
        sat = |hit;
    end

    // Rule register and age shift; a config write flushes everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rule_q <= '0;
            pend_q <= '0;
            viol   <= 1'b0;
        end else if (cfg_we) begin
            rule_q <= clamp_window(cfg_rule, MAX_LAT);
            pend_q <= '0;
            viol   <= 1'b0;
        end else begin
            pend_q <= keep;
            viol   <= viol_d;
        end
    end

endmodule

// File: rtl/ctrl_window_checker.sv
// rtl/ctrl_window_checker.sv - programmable control-timing checker top; CHK_COVER_EN adds per-rule coverage counters
module ctrl_window_checker
    import musa_chk_pkg::*;
#(
    parameter int NUM_RULES  = 8,
    parameter int CTRL_WIDTH = 10,
    parameter int MAX_LAT    = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_valid,
    input  logic [DATA_WIDTH-1:0]        instruction,
    input  logic [CTRL_WIDTH-1:0]        ctrl,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_RULES)-1:0] cfg_idx,
    input  rule_t                        cfg_rule,
    input  logic                         clr,
    output logic [NUM_RULES-1:0]         viol_pulse,
    output logic                         viol_sticky,
    output logic [CNT_WIDTH-1:0]         viol_count,
    output logic [$clog2(NUM_RULES)-1:0] first_viol_idx,
    output logic                         first_viol_valid
`ifdef CHK_COVER_EN
    ,
    input  logic [$clog2(NUM_RULES)-1:0] cov_idx,
    output logic [CNT_WIDTH-1:0]         cov_trig,
    output logic [CNT_WIDTH-1:0]         cov_sat
`endif
);

    localparam int IDX_W = $clog2(NUM_RULES);

    logic [NUM_RULES-1:0] fire;
    logic [NUM_RULES-1:0] sat;
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 unused_inst;

    assign opcode      = instruction[31:26];
    assign funct       = instruction[5:0];
    assign unused_inst = ^instruction[25:6];

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
        chk_rule_tracker #(.MAX_LAT(MAX_LAT)) u_trk (
            .clk        (clk),
            .rst        (rst),
            .inst_valid (inst_valid),
            .opcode     (opcode),
            .funct      (funct),
            .ctrl       (ctrl),
            .cfg_we     (cfg_we && (cfg_idx == IDX_W'(g))),
            .cfg_rule   (cfg_rule),
            .fire       (fire[g]),
            .sat        (sat[g]),
            .viol       (viol_pulse[g])
        );
    end

    logic [CNT_WIDTH-1:0] pc;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [IDX_W-1:0]     low_idx;
    logic                 any_viol;
    logic                 fv_base;

    // Popcount, lowest pulsing rule and clear-then-record status arithmetic
    always_comb begin
        pc      = '0;
        low_idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            pc = pc + CNT_WIDTH'(viol_pulse[i]);
            if (viol_pulse[i]) low_idx = IDX_W'(i);
        end
        any_viol = |viol_pulse;
        cnt_base = clr ? '0 : viol_count;
        cnt_sum  = {1'b0, cnt_base} + {1'b0, pc};
        cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        fv_base  = first_viol_valid & ~clr;
    end

    // Sticky flag, saturating count and first-violation capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_sticky      <= 1'b0;
            viol_count       <= '0;
            first_viol_idx   <= '0;
            first_viol_valid <= 1'b0;
        end else begin
            viol_sticky <= (viol_sticky & ~clr) | any_viol;
            viol_count  <= cnt_next;
            if (!fv_base && any_viol) begin
                first_viol_idx   <= low_idx;
                first_viol_valid <= 1'b1;
            end else begin
                first_viol_valid <= fv_base;
                if (clr) first_viol_idx <= '0;
            end
        end
    end

`ifdef CHK_COVER_EN
    logic [CNT_WIDTH-1:0] trig_cnt [NUM_RULES];
    logic [CNT_WIDTH-1:0] sat_cnt  [NUM_RULES];

    // Per-rule saturating trigger/satisfaction counters and registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                trig_cnt[i] <= '0;
                sat_cnt[i]  <= '0;
            end
            cov_trig <= '0;
            cov_sat  <= '0;
        end else begin
            for (int i = 0; i < NUM_RULES; i++) begin
                if (clr)
                    trig_cnt[i] <= CNT_WIDTH'(fire[i]);
                else if (fire[i] && (trig_cnt[i] != '1))
                    trig_cnt[i] <= trig_cnt[i] + CNT_WIDTH'(1);
                if (clr)
                    sat_cnt[i] <= CNT_WIDTH'(sat[i]);
                else if (sat[i] && (sat_cnt[i] != '1))
                    sat_cnt[i] <= sat_cnt[i] + CNT_WIDTH'(1);
            end
            cov_trig <= trig_cnt[cov_idx];
            cov_sat  <= sat_cnt[cov_idx];
        end
    end
`else
    logic unused_cov;
    assign unused_cov = ^{fire, sat};
`endif

endmodule

// File: tb/tb_ctrl_window_checker.sv
// tb/tb_ctrl_window_checker.sv - scoreboard bench with a trigger-list reference model
module tb_ctrl_window_checker;
    import musa_chk_pkg::*;

    localparam int NR   = 8;
    localparam int ML   = 4;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [9:0]  ctrl = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    rule_t       cfg_rule = '0;
    logic        clr = 1'b0;
    logic [7:0]  viol_pulse;
    logic        viol_sticky;
    logic [3:0]  viol_count;
    logic [2:0]  first_viol_idx;
    logic        first_viol_valid;

    ctrl_window_checker #(.NUM_RULES(NR), .CTRL_WIDTH(10), .MAX_LAT(ML),
                          .CNT_WIDTH(CNTW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .instruction(instruction),
        .ctrl(ctrl), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rule(cfg_rule),
        .clr(clr), .viol_pulse(viol_pulse), .viol_sticky(viol_sticky),
        .viol_count(viol_count), .first_viol_idx(first_viol_idx),
        .first_viol_valid(first_viol_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int t; } ent_t;
    typedef struct packed {
        logic [7:0] vp; logic st; logic [3:0] cnt; logic [2:0] idx; logic fv;
    } obs_t;

    obs_t sb[$];
    ent_t outst[$];
    bit         m_en[NR];
    logic [5:0] m_op[NR];
    logic [5:0] m_fn[NR];
    bit         m_fc[NR];
    logic [9:0] m_mask[NR];
    int         m_lo[NR];
    int         m_hi[NR];
    int         cyc = 0;
    logic [7:0] vp_prev = '0;
    int         m_cnt = 0;
    bit         m_st = 0, m_fv = 0;
    int         m_idx = 0;
    int         checks = 0, errors = 0;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_en[r] = 0; m_op[r] = '0; m_fn[r] = '0; m_fc[r] = 0;
            m_mask[r] = '0; m_lo[r] = 1; m_hi[r] = 1;
        end
        outst.delete(); sb.delete();
        vp_prev = '0; m_cnt = 0; m_st = 0; m_fv = 0; m_idx = 0;
    endtask

    // One clock of stimulus; the model decides what the DUT must show after the next edge
    task automatic step(bit iv, logic [5:0] op, logic [5:0] fn, logic [9:0] cv,
                        bit we, int idx, rule_t rr, bit cl);
        logic [7:0] vn;
        ent_t       keep[$];
        obs_t       e;
        int         a, lo, hi;
        @(negedge clk);
        inst_valid = iv; instruction = {op, 20'($urandom), fn}; ctrl = cv;
        cfg_we = we; cfg_idx = 3'(idx); cfg_rule = rr; clr = cl;
        vn = '0;
        foreach (outst[i]) begin
            a = cyc - outst[i].t;
            if (((cv & m_mask[outst[i].r]) == m_mask[outst[i].r]) &&
                a >= m_lo[outst[i].r] && a <= m_hi[outst[i].r]) begin
            end else if (a >= m_hi[outst[i].r]) vn[outst[i].r] = 1'b1;
            else keep.push_back(outst[i]);
        end
        outst = keep;
        for (int r = 0; r < NR; r++)
            if (m_en[r] && iv && op == m_op[r] && (!m_fc[r] || fn == m_fn[r]))
                outst.push_back('{r, cyc});
        if (we) begin
            keep.delete();
            foreach (outst[i]) if (outst[i].r != idx) keep.push_back(outst[i]);
            outst = keep;
            vn[idx] = 1'b0;
            lo = (rr.win_min == 0) ? 1 : int'(rr.win_min);
            hi = int'(rr.win_max);
            if (hi < lo || hi > ML) begin
                hi = ML;
                if (lo > ML) lo = ML;
            end
            m_en[idx] = rr.en; m_op[idx] = rr.opcode; m_fn[idx] = rr.funct;
            m_fc[idx] = rr.funct_care; m_mask[idx] = rr.mask; m_lo[idx] = lo; m_hi[idx] = hi;
        end
        if (cl) begin m_cnt = 0; m_st = 0; m_fv = 0; m_idx = 0; end
        if (vp_prev != 0) begin
            m_st = 1;
            m_cnt = m_cnt + $countones(vp_prev);
            if (m_cnt > CMAX) m_cnt = CMAX;
            if (!m_fv) begin
                m_fv = 1;
                for (int r = NR - 1; r >= 0; r--) if (vp_prev[r]) m_idx = r;
            end
        end
        e.vp = vn; e.st = m_st; e.cnt = 4'(m_cnt); e.idx = 3'(m_idx); e.fv = m_fv;
        sb.push_back(e);
        vp_prev = vn;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic go(logic [5:0] op, logic [5:0] fn, logic [9:0] cv);
        step(1, op, fn, cv, 0, 0, '0, 0);
    endtask

    task automatic cfg(int idx, bit en, logic [5:0] op, logic [5:0] fn, bit fc,
                       logic [9:0] mask, int lo, int hi);
        rule_t rr;
        rr.en = en; rr.opcode = op; rr.funct = fn; rr.funct_care = fc;
        rr.mask = mask; rr.win_min = 3'(lo); rr.win_max = 3'(hi);
        step(0, '0, '0, '0, 1, idx, rr, 0);
    endtask

    task automatic do_clr();
        step(0, '0, '0, '0, 0, 0, '0, 1);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(3))
            0: return OP_SW;
            1: return OP_LW;
            2: return OP_ADDI;
            default: return OP_RTYPE;
        endcase
    endfunction

    function automatic rule_t rand_rule();
        rule_t rr;
        rr.en = ($urandom_range(7) != 0);
        rr.opcode = pick_op();
        rr.funct = $urandom_range(1) ? FN_MULT : FN_DIV;
        rr.funct_care = $urandom_range(1);
        if ($urandom_range(7) == 0) rr.mask = '0;
        else rr.mask = (10'd1 << $urandom_range(9)) | ($urandom_range(1) ? (10'd1 << $urandom_range(9)) : 10'd0);
        rr.win_min = 3'($urandom_range(7));
        rr.win_max = 3'($urandom_range(7));
        return rr;
    endfunction

    // Monitor: compares every cycle's outputs with the oldest pending expectation
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = {viol_pulse, viol_sticky, viol_count, first_viol_idx, first_viol_valid};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL sb t=%0t: got vp=%h st=%0d cnt=%0d idx=%0d fv=%0d expected vp=%h st=%0d cnt=%0d idx=%0d fv=%0d",
                             $time, g.vp, g.st, g.cnt, g.idx, g.fv, e.vp, e.st, e.cnt, e.idx, e.fv);
                end
            end
        end
    end

    initial begin
        logic [9:0] mw, mr, rw, ps;
        mw = 10'd1 << CTRL_MEM_WRITE; mr = 10'd1 << CTRL_MEM_READ;
        rw = 10'd1 << CTRL_REG_WRITE; ps = 10'd1 << CTRL_PUSH;
        model_reset();
        #12;
        chk("reset_outputs", {viol_pulse, viol_sticky, viol_count, first_viol_idx, first_viol_valid}, 0);
        @(negedge clk); rst = 1'b0;

        // SW satisfied at age 2
        cfg(0, 1, OP_SW, 0, 0, mw, 1, 2);
        go(OP_SW, 0, 0); idle(1); step(0, 0, 0, mw, 0, 0, '0, 0); idle(4);
        settle(); chk("sw_count", viol_count, 0);

        // LW with mem_read only -> one violation on rule 1
        cfg(1, 1, OP_LW, 0, 0, mr | rw, 1, 2);
        go(OP_LW, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, mr, 0, 0, '0, 0);
        idle(3); settle();
        chk("lw_count", viol_count, 1);
        chk("lw_idx", first_viol_idx, 1);
        chk("lw_sticky", viol_sticky, 1);

        // Three back-to-back ADDI, single reg_write -> only the last one violates
        do_clr();
        cfg(2, 1, OP_ADDI, 0, 0, rw, 1, 2);
        go(OP_ADDI, 0, 0); go(OP_ADDI, 0, 0); go(OP_ADDI, 0, rw); idle(5);
        settle();
        chk("addi_count", viol_count, 1);
        chk("addi_idx", first_viol_idx, 2);

        // MULT funct filter
        cfg(3, 1, OP_RTYPE, FN_MULT, 1, rw, 1, 1);
        for (int i = 0; i < 3; i++) go(OP_RTYPE, FN_DIV, 0);
        idle(3); settle(); chk("mult_nomatch", viol_count, 1);
        go(OP_RTYPE, FN_MULT, 0); idle(4); settle(); chk("mult_match", viol_count, 2);

        // Config write flushes pending entries; oversized window clamps to MAX_LAT
        cfg(4, 1, 6'h0D, 0, 0, mw, 3, 4);
        go(6'h0D, 0, 0); go(6'h0D, 0, 0);
        cfg(4, 1, 6'h0D, 0, 0, mw, 3, 4);
        idle(6); settle(); chk("flush_count", viol_count, 2);
        cfg(4, 1, 6'h0D, 0, 0, mw, 1, 7);
        go(6'h0D, 0, 0); idle(7); settle(); chk("clamp_count", viol_count, 3);

        // clr coincident with two pulses
        cfg(5, 1, 6'h0E, 0, 0, ps, 1, 1);
        cfg(6, 1, 6'h0E, 0, 0, ps, 1, 1);
        go(6'h0E, 0, 0); idle(1); do_clr();
        settle();
        chk("clr_count", viol_count, 2);
        chk("clr_sticky", viol_sticky, 1);
        chk("clr_idx", first_viol_idx, 5);
        chk("clr_valid", first_viol_valid, 1);

        // Saturation after 20 violations
        do_clr();
        cfg(7, 1, 6'h0F, 0, 0, mw, 1, 1);
        for (int i = 0; i < 20; i++) go(6'h0F, 0, 0);
        idle(3); settle(); chk("sat_count", viol_count, CMAX);

        // Randomized traffic including mid-stream config writes and clears
        do_clr();
        for (int r = 0; r < NR; r++) step(0, 0, 0, 0, 1, r, rand_rule(), 0);
        for (int i = 0; i < 500; i++)
            step($urandom_range(3) != 0, pick_op(), $urandom_range(1) ? FN_MULT : FN_DIV,
                 10'($urandom), $urandom_range(31) == 0, $urandom_range(NR - 1), rand_rule(),
                 $urandom_range(31) == 0);

        // Asynchronous reset mid-operation
        for (int r = 0; r < NR; r++) step(0, 0, 0, 0, 1, r, rand_rule(), 0);
        for (int i = 0; i < 6; i++) go(pick_op(), FN_MULT, '0);
        @(posedge clk); #3; rst = 1'b1; #1;
        chk("async_reset", {viol_pulse, viol_sticky, viol_count, first_viol_idx, first_viol_valid}, 0);
        model_reset();
        @(negedge clk); inst_valid = 0; cfg_we = 0; clr = 0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) go(pick_op(), FN_MULT, '0);
        idle(6);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
